// File: rtl/mmio_pkg.sv
// Shared definitions for the load/store MMIO splitter: register map,
// timer control bit positions and the word-address decoder.
package mmio_pkg;

   localparam logic [15:0] MMIO_LEDR    = 16'h8000;
   localparam logic [15:0] MMIO_SW      = 16'h8002;
   localparam logic [15:0] MMIO_TCOUNT  = 16'h8004;
   localparam logic [15:0] MMIO_TCTRL   = 16'h8006;
   localparam logic [15:0] MMIO_TSTAT   = 16'h8008;
   localparam logic [15:0] MMIO_TPERIOD = 16'h800A;

   localparam int unsigned CTRL_EN    = 0;
   localparam int unsigned CTRL_AUTO  = 1;
   localparam int unsigned CTRL_IRQEN = 2;

   typedef enum logic [2:0] {
      REG_LEDR,
      REG_SW,
      REG_TCOUNT,
      REG_TCTRL,
      REG_TSTAT,
      REG_TPERIOD,
      REG_NONE
   } mmio_reg_e;

   // Takes the word address (byte address bits 15:1); RAM-side addresses
   // never match because every map entry has bit 15 set.
   function automatic mmio_reg_e mmio_decode(input logic [14:0] word_addr);
      mmio_reg_e sel;
      sel = REG_NONE;
      if      (word_addr == MMIO_LEDR[15:1])    sel = REG_LEDR;
      else if (word_addr == MMIO_SW[15:1])      sel = REG_SW;
      else if (word_addr == MMIO_TCOUNT[15:1])  sel = REG_TCOUNT;
      else if (word_addr == MMIO_TCTRL[15:1])   sel = REG_TCTRL;
      else if (word_addr == MMIO_TSTAT[15:1])   sel = REG_TSTAT;
      else if (word_addr == MMIO_TPERIOD[15:1]) sel = REG_TPERIOD;
      return sel;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Prescaled countdown timer with one-shot / auto-reload modes and a
// sticky expiry flag driving a level interrupt.
module mmio_timer
   import mmio_pkg::*;
#(
   parameter logic [15:0] PRESCALE = 16'd50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_wr_tcount,
   input  logic        i_wr_tctrl,
   input  logic        i_wr_tstat,
   input  logic        i_wr_tperiod,
   input  logic [15:0] i_wdata,
   output logic [15:0] o_tcount,
   output logic [2:0]  o_tctrl,
   output logic        o_flag,
   output logic [15:0] o_tperiod,
   output logic        o_irq
);

   localparam logic [15:0] PRESC_MAX = PRESCALE - 16'd1;

   logic [15:0] r_presc;
   logic [15:0] r_tcount;
   logic [15:0] r_tperiod;
   logic [2:0]  r_ctrl;
   logic        r_flag;

   logic w_en;
   logic w_presc_zero;
   logic w_en_clear;
   logic w_en_rise;
   logic w_tick;
   logic w_expire;

   assign w_en         = r_ctrl[CTRL_EN];
   assign w_presc_zero = (r_presc == '0);
   assign w_en_clear   = i_wr_tctrl & ~i_wdata[CTRL_EN];
   assign w_en_rise    = i_wr_tctrl &  i_wdata[CTRL_EN] & ~w_en;
   // A TCTRL write that clears EN swallows a tick landing on the same edge.
   assign w_tick       = w_en & w_presc_zero & ~w_en_clear;
   assign w_expire     = w_tick & (r_tcount == '0);

   // Prescaler: reload on enable, otherwise count down while enabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          r_presc <= '0;
      else if (w_en_rise)  r_presc <= PRESC_MAX;
      else if (w_en)       r_presc <= w_presc_zero ? PRESC_MAX : r_presc - 16'd1;
   end

   // Countdown register: CPU write beats any tick-driven update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             r_tcount <= '0;
      else if (i_wr_tcount)                   r_tcount <= i_wdata;
      else if (w_expire && r_ctrl[CTRL_AUTO]) r_tcount <= r_tperiod;
      else if (w_tick && r_tcount != '0)      r_tcount <= r_tcount - 16'd1;
   end

   // Reload period register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            r_tperiod <= '0;
      else if (i_wr_tperiod) r_tperiod <= i_wdata;
   end

   // Control register; one-shot expiry drops EN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                               r_ctrl <= '0;
      else if (i_wr_tctrl)                      r_ctrl <= i_wdata[2:0];
      else if (w_expire && !r_ctrl[CTRL_AUTO])  r_ctrl[CTRL_EN] <= 1'b0;
   end

   // Expiry flag: a set on the same edge as a clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        r_flag <= 1'b0;
      else if (w_expire)                 r_flag <= 1'b1;
      else if (i_wr_tstat && i_wdata[0]) r_flag <= 1'b0;
   end

   assign o_tcount  = r_tcount;
   assign o_tctrl   = r_ctrl;
   assign o_flag    = r_flag;
   assign o_tperiod = r_tperiod;
   assign o_irq     = r_flag & r_ctrl[CTRL_IRQEN];

endmodule

// File: rtl/ldst_mmio.sv
// Data-side splitter: lower half of the address space to RAM, upper half to
// LEDs, synchronized switches and the timer. Read data returns one cycle
// after the request and holds between reads.
module ldst_mmio
   import mmio_pkg::*;
#(
   parameter logic [15:0] PRESCALE = 16'd50,
   parameter int unsigned SW_W     = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [15:0]     i_ldst_addr,
   input  logic            i_ldst_rd,
   input  logic            i_ldst_wr,
   input  logic [15:0]     i_ldst_wrdata,
   output logic [15:0]     o_ldst_rddata,
   output logic [14:0]     o_ram_addr,
   output logic            o_ram_rd,
   output logic            o_ram_wr,
   output logic [15:0]     o_ram_wrdata,
   input  logic [15:0]     i_ram_rddata,
   input  logic [SW_W-1:0] i_sw,
   output logic [SW_W-1:0] o_ledr,
   output logic            o_timer_irq
);

   logic [SW_W-1:0] r_ledr;
   logic [SW_W-1:0] r_sw_meta;
   logic [SW_W-1:0] r_sw_sync;
   logic            r_rd_valid;
   logic            r_rd_mmio;
   logic [15:0]     r_mmio_rdata;
   logic [15:0]     r_rddata_hold;

   logic            w_is_mmio;
   logic            w_mmio_wr;
   mmio_reg_e       w_reg;
   logic [15:0]     w_mmio_rdata;
   logic [15:0]     w_rddata;
   logic [15:0]     w_tcount;
   logic [15:0]     w_tperiod;
   logic [2:0]      w_tctrl;
   logic            w_flag;
   logic            w_unused;

   assign w_is_mmio = i_ldst_addr[15];
   assign w_mmio_wr = i_ldst_wr & w_is_mmio;
   assign w_reg     = mmio_decode(i_ldst_addr[15:1]);
   assign w_unused  = i_ldst_addr[0];

   assign o_ram_addr   = {1'b0, i_ldst_addr[14:1]};
   assign o_ram_rd     = i_ldst_rd & ~w_is_mmio;
   assign o_ram_wr     = i_ldst_wr & ~w_is_mmio;
   assign o_ram_wrdata = i_ldst_wrdata;

   mmio_timer #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .i_wr_tcount  (w_mmio_wr && w_reg == REG_TCOUNT),
      .i_wr_tctrl   (w_mmio_wr && w_reg == REG_TCTRL),
      .i_wr_tstat   (w_mmio_wr && w_reg == REG_TSTAT),
      .i_wr_tperiod (w_mmio_wr && w_reg == REG_TPERIOD),
      .i_wdata      (i_ldst_wrdata),
      .o_tcount     (w_tcount),
      .o_tctrl      (w_tctrl),
      .o_flag       (w_flag),
      .o_tperiod    (w_tperiod),
      .o_irq        (o_timer_irq)
   );

   // LED register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              r_ledr <= '0;
      else if (w_mmio_wr && w_reg == REG_LEDR) r_ledr <= i_ldst_wrdata[SW_W-1:0];
   end

   // Two-flop switch synchronizer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= i_sw;
         r_sw_sync <= r_sw_meta;
      end
   end

   // MMIO read mux, zero-extended; sampled before any same-edge write lands.
   always_comb begin
      w_mmio_rdata = '0;
      case (w_reg)
         REG_LEDR:    w_mmio_rdata[SW_W-1:0] = r_ledr;
         REG_SW:      w_mmio_rdata[SW_W-1:0] = r_sw_sync;
         REG_TCOUNT:  w_mmio_rdata           = w_tcount;
         REG_TCTRL:   w_mmio_rdata[2:0]      = w_tctrl;
         REG_TSTAT:   w_mmio_rdata[0]        = w_flag;
         REG_TPERIOD: w_mmio_rdata           = w_tperiod;
         default:     w_mmio_rdata           = '0;
      endcase
   end

   // Read-return registers: source select and MMIO value captured at request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_valid   <= 1'b0;
         r_rd_mmio    <= 1'b0;
         r_mmio_rdata <= '0;
      end else begin
         r_rd_valid <= i_ldst_rd;
         if (i_ldst_rd) begin
            r_rd_mmio    <= w_is_mmio;
            r_mmio_rdata <= w_mmio_rdata;
         end
      end
   end

   // RAM data is only valid in the return cycle, so keep a copy for holding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          r_rddata_hold <= '0;
      else if (r_rd_valid) r_rddata_hold <= w_rddata;
   end

   assign w_rddata      = r_rd_valid ? (r_rd_mmio ? r_mmio_rdata : i_ram_rddata)
                                     : r_rddata_hold;
   assign o_ldst_rddata = w_rddata;
   assign o_ledr        = r_ledr;

endmodule

// File: tb/tb_ldst_mmio.sv
// Directed self-checking bench for ldst_mmio with PRESCALE=4.
module tb_ldst_mmio;

   localparam int unsigned SW_W = 10;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [15:0]     i_ldst_addr = '0;
   logic            i_ldst_rd = 1'b0;
   logic            i_ldst_wr = 1'b0;
   logic [15:0]     i_ldst_wrdata = '0;
   logic [15:0]     o_ldst_rddata;
   logic [14:0]     o_ram_addr;
   logic            o_ram_rd;
   logic            o_ram_wr;
   logic [15:0]     o_ram_wrdata;
   logic [15:0]     i_ram_rddata = '0;
   logic [SW_W-1:0] i_sw = '0;
   logic [SW_W-1:0] o_ledr;
   logic            o_timer_irq;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [15:0] mem [0:255];

   ldst_mmio #(
      .PRESCALE (16'd4),
      .SW_W     (SW_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_ldst_addr   (i_ldst_addr),
      .i_ldst_rd     (i_ldst_rd),
      .i_ldst_wr     (i_ldst_wr),
      .i_ldst_wrdata (i_ldst_wrdata),
      .o_ldst_rddata (o_ldst_rddata),
      .o_ram_addr    (o_ram_addr),
      .o_ram_rd      (o_ram_rd),
      .o_ram_wr      (o_ram_wr),
      .o_ram_wrdata  (o_ram_wrdata),
      .i_ram_rddata  (i_ram_rddata),
      .i_sw          (i_sw),
      .o_ledr        (o_ledr),
      .o_timer_irq   (o_timer_irq)
   );

   always #5 clk = ~clk;

   // Synchronous RAM model
   always @(posedge clk) begin
      if (o_ram_wr) mem[o_ram_addr[7:0]] <= o_ram_wrdata;
      if (o_ram_rd) i_ram_rddata <= mem[o_ram_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_wr(input logic [15:0] addr, input logic [15:0] data);
      i_ldst_addr   = addr;
      i_ldst_wrdata = data;
      i_ldst_wr     = 1'b1;
      @(posedge clk);
      #1;
      i_ldst_wr = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      i_ldst_addr = addr;
      i_ldst_rd   = 1'b1;
      @(posedge clk);
      #1;
      i_ldst_rd = 1'b0;
      chk(tag, o_ldst_rddata, exp);
   endtask

   initial begin
      // Reset
      #1 reset = 1'b0;
      #1;
      chk("rst_rddata", o_ldst_rddata, 16'h0000);
      chk("rst_ledr", {6'd0, o_ledr}, 16'h0000);
      chk("rst_irq", {15'd0, o_timer_irq}, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      cyc(1);

      // RAM pass-through
      i_ldst_addr = 16'h0010; i_ldst_wrdata = 16'h1234; i_ldst_wr = 1'b1;
      #1;
      chk("ram_wr_addr", {1'b0, o_ram_addr}, 16'h0008);
      chk("ram_wr_strobe", {14'd0, o_ram_wr, o_ram_rd}, 16'h0002);
      chk("ram_wrdata", o_ram_wrdata, 16'h1234);
      cyc(1);
      i_ldst_wr = 1'b0;
      i_ldst_rd = 1'b1;
      #1;
      chk("ram_rd_strobe", {14'd0, o_ram_wr, o_ram_rd}, 16'h0001);
      chk("ram_rd_addr", {1'b0, o_ram_addr}, 16'h0008);
      cyc(1);
      i_ldst_rd = 1'b0;
      chk("ram_rddata", o_ldst_rddata, 16'h1234);
      chk("ram_ledr_untouched", {6'd0, o_ledr}, 16'h0000);
      rdchk("ram_tcount_untouched", 16'h8004, 16'h0000);

      // LED write, RAM strobes held low for MMIO
      i_ldst_addr = 16'h8000; i_ldst_wrdata = 16'h03FF; i_ldst_wr = 1'b1;
      #1;
      chk("mmio_ram_wr_low", {15'd0, o_ram_wr}, 16'h0000);
      cyc(1);
      i_ldst_wr = 1'b0;
      chk("ledr_out", {6'd0, o_ledr}, 16'h03FF);
      rdchk("ledr_rd", 16'h8000, 16'h03FF);
      i_ldst_rd = 1'b1;
      #1;
      chk("mmio_ram_rd_low", {15'd0, o_ram_rd}, 16'h0000);
      i_ldst_rd = 1'b0;

      // Switch synchronizer latency
      i_sw = 10'h155;
      rdchk("sw_cyc1", 16'h8002, 16'h0000);
      rdchk("sw_cyc2", 16'h8002, 16'h0000);
      rdchk("sw_cyc3", 16'h8002, 16'h0155);

      // Unmapped read and write
      rdchk("unmapped_rd", 16'h80FE, 16'h0000);
      do_wr(16'h80FE, 16'hFFFF);
      rdchk("unmapped_wr_ignored", 16'h8000, 16'h03FF);

      // Simultaneous read and write returns the pre-write value
      i_ldst_addr = 16'h8000; i_ldst_wrdata = 16'h00AA;
      i_ldst_rd = 1'b1; i_ldst_wr = 1'b1;
      cyc(1);
      i_ldst_rd = 1'b0; i_ldst_wr = 1'b0;
      chk("rdwr_old", o_ldst_rddata, 16'h03FF);
      chk("rdwr_ledr", {6'd0, o_ledr}, 16'h00AA);
      cyc(3);
      chk("rddata_hold", o_ldst_rddata, 16'h03FF);
      rdchk("ledr_new", 16'h8000, 16'h00AA);

      // One-shot timer: ticks at +4 (2->1), +8 (1->0), +12 (expire)
      do_wr(16'h8004, 16'h0002);
      do_wr(16'h8006, 16'h0005);
      cyc(11);
      chk("oneshot_irq_pre", {15'd0, o_timer_irq}, 16'h0000);
      cyc(1);
      chk("oneshot_irq_set", {15'd0, o_timer_irq}, 16'h0001);
      rdchk("oneshot_tctrl", 16'h8006, 16'h0004);
      rdchk("oneshot_tcount", 16'h8004, 16'h0000);
      cyc(8);
      rdchk("oneshot_tcount_held", 16'h8004, 16'h0000);
      rdchk("oneshot_tstat", 16'h8008, 16'h0001);
      do_wr(16'h8008, 16'h0001);
      chk("oneshot_irq_clr", {15'd0, o_timer_irq}, 16'h0000);

      // Auto-reload: period 3 -> expiry every 16 cycles; enable write is E0
      do_wr(16'h800A, 16'h0003);
      rdchk("tperiod_rd", 16'h800A, 16'h0003);
      do_wr(16'h8004, 16'h0003);
      do_wr(16'h8006, 16'h0007);
      cyc(15);
      chk("auto_irq_pre", {15'd0, o_timer_irq}, 16'h0000);
      cyc(1);
      chk("auto_irq_e16", {15'd0, o_timer_irq}, 16'h0001);
      cyc(3);
      do_wr(16'h8008, 16'h0001);                      // E20
      chk("auto_clr", {15'd0, o_timer_irq}, 16'h0000);
      cyc(11);
      do_wr(16'h8008, 16'h0001);                      // E32, coincides with set
      chk("auto_set_wins", {15'd0, o_timer_irq}, 16'h0001);
      rdchk("auto_reload", 16'h8004, 16'h0003);       // E33
      cyc(2);
      do_wr(16'h8004, 16'h0100);                      // E36, tick
      rdchk("tcount_write_wins", 16'h8004, 16'h0100); // E37
      cyc(2);
      do_wr(16'h8006, 16'h0000);                      // E40, tick dropped
      rdchk("tick_dropped", 16'h8004, 16'h0100);
      do_wr(16'h8008, 16'h0001);
      rdchk("flag_cleared", 16'h8008, 16'h0000);

      // Asynchronous reset mid-countdown
      do_wr(16'h8000, 16'h02AA);
      do_wr(16'h800A, 16'h0005);
      do_wr(16'h8004, 16'h0000);
      do_wr(16'h8006, 16'h0007);                      // E0
      cyc(4);
      chk("pre_rst_irq", {15'd0, o_timer_irq}, 16'h0001);
      rdchk("pre_rst_ledr", 16'h8000, 16'h02AA);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_rddata", o_ldst_rddata, 16'h0000);
      chk("async_rst_ledr", {6'd0, o_ledr}, 16'h0000);
      chk("async_rst_irq", {15'd0, o_timer_irq}, 16'h0000);
      @(negedge clk) reset = 1'b1;
      cyc(20);
      chk("post_rst_irq", {15'd0, o_timer_irq}, 16'h0000);
      rdchk("post_rst_tctrl", 16'h8006, 16'h0000);
      rdchk("post_rst_tcount", 16'h8004, 16'h0000);
      rdchk("post_rst_tperiod", 16'h800A, 16'h0000);
      rdchk("post_rst_tstat", 16'h8008, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ldst_mmio.md
# ldst_mmio

Data-side memory port splitter between the pipelined CPU's load/store interface and the board. Decodes each access: the lower half of the address space goes to data RAM, the upper half to a small memory-mapped I/O region. The MMIO region holds LEDs, synchronized switches and a prescaled countdown timer with interrupt. Returns read data to the CPU's execute stage one cycle after the request.

## Interface
- PRESCALE, 16'd50: clock cycles per timer tick, must be ≥ 1
- SW_W, 10: switch and LED width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- i_ldst_addr  in  16  byte address from CPU; bit 0 ignored
- i_ldst_rd  in  1  read request
- i_ldst_wr  in  1  write request
- i_ldst_wrdata  in  16  write data
- o_ldst_rddata  out  16  read data, valid cycle after i_ldst_rd
- o_ram_addr  out  15  word address to RAM, equal to i_ldst_addr[15:1] with bit 15 cleared
- o_ram_rd / o_ram_wr  out  1  RAM strobes, combinational
- o_ram_wrdata  out  16  = i_ldst_wrdata
- i_ram_rddata  in  16  synchronous RAM output, valid cycle after o_ram_rd
- i_sw  in  SW_W  asynchronous switches
- o_ledr  out  SW_W  LED register
- o_timer_irq  out  1  timer interrupt, level

## Operation
- Decode on addr[15]:
  - 0 selects RAM: strobes pass through combinationally.
  - 1 selects MMIO: RAM strobes are held low.
- MMIO map (word-aligned):
  - 0x8000 LEDR: R/W, low SW_W bits.
  - 0x8002 SW: read-only, zero-extended.
  - 0x8004 TCOUNT: R/W.
  - 0x8006 TCTRL: R/W. bit0 EN, bit1 AUTO, bit2 IRQEN; other bits read 0.
  - 0x8008 TSTAT: bit0 FLAG. Writing 1 clears FLAG.
  - 0x800A TPERIOD: R/W.
- Unmapped MMIO addresses read 0x0000; writes to them are ignored.
- Read path:
  - The source select and the MMIO read value are registered at the request edge.
  - o_ldst_rddata is driven from i_ram_rddata or the registered MMIO value.
  - When no read occurred in the previous cycle, o_ldst_rddata holds its last value.
- rd and wr in the same cycle: the write is performed; the read returns the pre-write value.
- Switch input: two-flop synchronizer. The SW register returns the second flop.
- Timer:
  - When EN=1, the prescaler counts PRESCALE-1 down to 0; reaching 0 issues one tick and reloads.
  - On a tick with TCOUNT≠0: TCOUNT decrements.
  - On a tick with TCOUNT=0: FLAG is set. If AUTO=1, TCOUNT←TPERIOD; otherwise EN←0.
  - EN=0 holds both the prescaler and TCOUNT.
  - Writing TCTRL with EN 0→1 reloads the prescaler.
- o_timer_irq = FLAG & IRQEN.

## Timing
- Reset values, all asserted immediately on reset low:
  - Registers: LEDR, TCOUNT, TCTRL, FLAG, TPERIOD, prescaler and synchronizer = 0.
  - Outputs: o_ldst_rddata=0, o_ledr=0, o_timer_irq=0.
- Read latency is 1 cycle for both RAM and MMIO.
- MMIO writes take effect at the request edge and are visible to a read in the next cycle.
- SW latency: an input change appears in the SW register after 2 edges and is readable on the 3rd cycle.
- Conflicts between a CPU write and a timer tick in the same cycle:
  - Write to TCOUNT coincident with a tick: the write wins.
  - Write to TSTAT with bit0=1 coincident with FLAG set: set wins, FLAG stays 1.
  - Write to TCTRL clearing EN coincident with a tick: that tick is dropped.
- Reset mid-count stops the timer and clears FLAG; the first tick after release is PRESCALE cycles after EN is set.

## Structure
- Package mmio_pkg holds:
  - Address constants MMIO_LEDR … MMIO_TPERIOD.
  - TCTRL bit indices: CTRL_EN, CTRL_AUTO, CTRL_IRQEN.
- Sub-module mmio_timer contains the prescaler, TCOUNT, TPERIOD, TCTRL and FLAG. Its interface is write strobes plus data in, register values out, and the irq output.
- Top ldst_mmio contains the decode, the read-return registers, LEDR and the synchronizer.

## Test plan
- RAM pass-through: wr 0x1234 to 0x0010, then rd 0x0010 → o_ram_addr=0x0008 with strobes; rddata = RAM value one cycle later; MMIO state unchanged.
- LED/SW: wr 0x03FF to 0x8000 → o_ledr=0x3FF. i_sw=0x155 → read of 0x8002 returns 0x0155 only from the 3rd cycle after the change.
- One-shot timer, PRESCALE=4:
  - Setup: TCOUNT=2, TCTRL=0x5.
  - FLAG and irq rise 12 cycles after the enable write.
  - EN reads 0; TCOUNT stays 0.
  - Writing 1 to TSTAT drops irq next cycle.
- Auto-reload, TPERIOD=3: FLAG is set and TCOUNT reloads to 3 every 16 cycles. A TSTAT clear coincident with a set leaves FLAG=1.
- Unmapped/conflict: rd 0x80FE → 0x0000. Simultaneous rd+wr 0x00AA to 0x8000 → rddata is the old LEDR; o_ledr=0x0AA.
- Async reset asserted mid-countdown → all outputs 0 without a clock edge; timer idle after release.
